dac_stream_sequencer: RTL

- Session controller for the output-board DAC path, in the capture_clk domain.
- Sequences DAC reset release, FIFO prefill, frame-aligned enable of multi_dac_interface, underrun supervision and graceful drain/stop.
- Drives the interface enable and DAC_NOT_RST, plus a mute that forces dac_buffer_reg output to zero.
- Reports state, underrun statistics and fault status.

---
 rtl/dac_stream_if.sv | 28 ++
 rtl/dac_stream_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dac_stream_if.sv
// Signal bundle between the host-side FIFO/DAC datapath and the DAC session sequencer.
// dac_request and dac_underrun are single-cycle strobes sampled on capture_clk; nothing on this path applies backpressure.
interface dac_stream_if #(
  parameter int LEVEL_W = 10
);
  logic               fifo_open;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_empty;
  logic               dac_request;
  logic               dac_underrun;
  logic               dac_enable;
  logic               dac_not_rst;
  logic               mute;
  logic               running;
  logic               fault;
  logic [7:0]         underrun_count;
  logic [2:0]         state;

  modport master (
    output fifo_open, fifo_level, fifo_empty, dac_request, dac_underrun,
    input  dac_enable, dac_not_rst, mute, running, fault, underrun_count, state
  );

  modport slave (
    input  fifo_open, fifo_level, fifo_empty, dac_request, dac_underrun,
    output dac_enable, dac_not_rst, mute, running, fault, underrun_count, state
  );
endinterface

// File: rtl/dac_stream_sequencer.sv
// DAC session controller: reset release, FIFO prefill, frame-aligned enable,
// underrun supervision and drain/stop. All outputs are registered from the next state.
module dac_stream_sequencer #(
  parameter int dac_channels   = 4,
  parameter int RESET_HOLD     = 64,
  parameter int PREFILL        = 16,
  parameter int UNDERRUN_LIMIT = 3,
  parameter int LEVEL_W        = 10
) (
  input  logic         capture_clk,
  input  logic         reset,
  dac_stream_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RST     = 3'd1,
    S_PREFILL = 3'd2,
    S_ARM     = 3'd3,
    S_RUN     = 3'd4,
    S_DRAIN   = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  // Never enable with less than one complete frame buffered.
  localparam int                 PREFILL_WORDS = (PREFILL < dac_channels) ? dac_channels : PREFILL;
  localparam logic [LEVEL_W-1:0] PREFILL_LVL   = LEVEL_W'(PREFILL_WORDS);
  localparam int                 HOLD_W        = $clog2(RESET_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD     = HOLD_W'(RESET_HOLD - 1);
  localparam logic [3:0]         LIMIT         = 4'(UNDERRUN_LIMIT);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        ucnt_q, ucnt_d;
  logic [3:0]        consec_q, consec_d;
  logic              drain_mute_q, drain_mute_d;
  logic              en_q, en_d;
  logic              nrst_q, nrst_d;
  logic              mute_q, mute_d;
  logic              run_q, run_d;
  logic              fault_q, fault_d;
  logic              count_und;

  assign count_und = bus.dac_underrun && (state_q == S_RUN || state_q == S_DRAIN);

  always_ff @(posedge capture_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      ucnt_q       <= '0;
      consec_q     <= '0;
      drain_mute_q <= 1'b0;
      en_q         <= 1'b0;
      nrst_q       <= 1'b0;
      mute_q       <= 1'b1;
      run_q        <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      ucnt_q       <= ucnt_d;
      consec_q     <= consec_d;
      drain_mute_q <= drain_mute_d;
      en_q         <= en_d;
      nrst_q       <= nrst_d;
      mute_q       <= mute_d;
      run_q        <= run_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    ucnt_d       = ucnt_q;
    consec_d     = consec_q;
    drain_mute_d = 1'b0;
    if (count_und && ucnt_q != 8'hFF) ucnt_d = ucnt_q + 8'd1;
    case (state_q)
      S_IDLE: begin
        if (bus.fifo_open) begin
          state_d  = S_RST;
          hold_d   = HOLD_LOAD;
          ucnt_d   = '0;
          consec_d = '0;
        end
      end
      S_RST: begin
        if (!bus.fifo_open)     state_d = S_IDLE;
        else if (hold_q == '0)  state_d = S_PREFILL;
        else                    hold_d  = hold_q - 1'b1;
      end
      S_PREFILL: begin
        if (!bus.fifo_open)                    state_d = S_IDLE;
        else if (bus.fifo_level >= PREFILL_LVL) state_d = S_ARM;
      end
      S_ARM: begin
        if (!bus.fifo_open)      state_d = S_IDLE;
        else if (bus.dac_request) state_d = S_RUN;
      end
      S_RUN: begin
        // An underrun in the same cycle as a request wins over the clear.
        if (bus.dac_underrun)
          consec_d = (consec_q == 4'hF) ? consec_q : consec_q + 4'd1;
        else if (bus.dac_request && !bus.fifo_empty)
          consec_d = '0;
        if (!bus.fifo_open)        state_d = S_DRAIN;
        else if (consec_d >= LIMIT) state_d = S_FAULT;
      end
      S_DRAIN: begin
        drain_mute_d = drain_mute_q | bus.fifo_empty;
        if (drain_mute_q && bus.dac_request) begin
          state_d      = S_IDLE;
          drain_mute_d = 1'b0;
        end
      end
      S_FAULT: begin
        if (!bus.fifo_open) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    en_d    = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_DRAIN);
    nrst_d  = (state_d != S_IDLE) && (state_d != S_RST);
    run_d   = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
    case (state_d)
      S_RUN:   mute_d = 1'b0;
      S_DRAIN: mute_d = drain_mute_d;
      default: mute_d = 1'b1;
    endcase
  end

  assign bus.dac_enable     = en_q;
  assign bus.dac_not_rst    = nrst_q;
  assign bus.mute           = mute_q;
  assign bus.running        = run_q;
  assign bus.fault          = fault_q;
  assign bus.underrun_count = ucnt_q;
  assign bus.state          = state_q;

endmodule
